// File: rtl/dmac_bus_arbiter.sv
// Two-master / two-slave arbiter and interconnect in front of the DMAC.
// The host parks on the bus. The DMAC keeps it for as long as it holds its request.
module dmac_bus_arbiter #(
    parameter logic [2:0] MEM_BASE  = 3'b000,
    parameter logic [2:0] DMAC_BASE = 3'b001
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        M0_req,
    input  logic        M0_wr,
    input  logic [7:0]  M0_address,
    input  logic [31:0] M0_dout,
    input  logic        M1_req,
    input  logic        M1_wr,
    input  logic [7:0]  M1_address,
    input  logic [31:0] M1_dout,
    output logic        M0_grant,
    output logic        M1_grant,
    output logic [31:0] M_din,
    output logic        S0_sel,
    output logic        S1_sel,
    output logic        S_wr,
    output logic [7:0]  S_address,
    output logic [31:0] S_din,
    input  logic [31:0] S0_dout,
    input  logic [31:0] S1_dout
);

    typedef enum logic {GNT0 = 1'b0, GNT1 = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [1:0] rd_sel_q, rd_sel_d;
    logic       own1;
    logic       g_req;
    logic       g_wr;

    // While reset is held the host path drives the bus, whatever the state register holds.
    always_comb begin
        own1      = (state_q == GNT1) && !reset;
        g_req     = own1 ? M1_req     : M0_req;
        g_wr      = own1 ? M1_wr      : M0_wr;
        S_address = own1 ? M1_address : M0_address;
        S_din     = own1 ? M1_dout    : M0_dout;
        S_wr      = g_req & g_wr;
        S0_sel    = g_req && (S_address[7:5] == MEM_BASE);
        S1_sel    = g_req && (S_address[7:5] == DMAC_BASE);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            GNT0:    if (!M0_req && M1_req) state_d = GNT1;
            GNT1:    if (!M1_req)           state_d = GNT0;
            default: state_d = GNT0;
        endcase
        rd_sel_d = {S1_sel & ~S_wr, S0_sel & ~S_wr};
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q  <= GNT0;
            rd_sel_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    // A read still in flight when reset arrives is dropped rather than returned.
    always_comb begin
        M0_grant = (state_q == GNT0) || reset;
        M1_grant = (state_q == GNT1) && !reset;
        if (reset)            M_din = 32'h0;
        else if (rd_sel_q[1]) M_din = S1_dout;
        else if (rd_sel_q[0]) M_din = S0_dout;
        else                  M_din = 32'h0;
    end

endmodule

// File: tb/tb_dmac_bus_arbiter.sv
// Bench for dmac_bus_arbiter: behavioural slaves, an ownership/read-return model,
// directed scenarios and a randomized traffic run.
module tb_dmac_bus_arbiter;

    logic        Clk = 1'b0;
    logic        reset;
    logic        M0_req, M0_wr, M1_req, M1_wr;
    logic [7:0]  M0_address, M1_address;
    logic [31:0] M0_dout, M1_dout;
    logic        M0_grant, M1_grant;
    logic [31:0] M_din;
    logic        S0_sel, S1_sel, S_wr;
    logic [7:0]  S_address;
    logic [31:0] S_din;
    logic [31:0] S0_dout, S1_dout;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    dmac_bus_arbiter dut (
        .Clk(Clk), .reset(reset),
        .M0_req(M0_req), .M0_wr(M0_wr), .M0_address(M0_address), .M0_dout(M0_dout),
        .M1_req(M1_req), .M1_wr(M1_wr), .M1_address(M1_address), .M1_dout(M1_dout),
        .M0_grant(M0_grant), .M1_grant(M1_grant), .M_din(M_din),
        .S0_sel(S0_sel), .S1_sel(S1_sel), .S_wr(S_wr), .S_address(S_address), .S_din(S_din),
        .S0_dout(S0_dout), .S1_dout(S1_dout)
    );

    // Registered slaves: memory and the DMAC register file.
    logic [31:0] mem_s0 [32];
    logic [31:0] reg_s1 [32];
    always @(posedge Clk) begin
        if (S0_sel) begin
            if (S_wr) mem_s0[S_address[4:0]] <= S_din;
            else      S0_dout <= mem_s0[S_address[4:0]];
        end
        if (S1_sel) begin
            if (S_wr) reg_s1[S_address[4:0]] <= S_din;
            else      S1_dout <= reg_s1[S_address[4:0]];
        end
    end

    // Reference: who owns the bus, the slave contents, and the read result due next cycle.
    bit          m_own = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic [31:0] r_mem [32];
    logic [31:0] r_reg [32];

    task automatic adv();
        logic        own, req, wr;
        logic [7:0]  a;
        logic [31:0] d;
        @(posedge Clk);
        own = m_own && !reset;
        req = own ? M1_req : M0_req;
        wr  = own ? M1_wr : M0_wr;
        a   = own ? M1_address : M0_address;
        d   = own ? M1_dout : M0_dout;
        m_rdata = 32'h0;
        if (req && wr) begin
            if (a[7:5] == 3'd0)      r_mem[a[4:0]] = d;
            else if (a[7:5] == 3'd1) r_reg[a[4:0]] = d;
        end else if (req && !reset) begin
            if (a[7:5] == 3'd0)      m_rdata = r_mem[a[4:0]];
            else if (a[7:5] == 3'd1) m_rdata = r_reg[a[4:0]];
        end
        if (reset)     m_own = 1'b0;
        else if (!own) m_own = !M0_req && M1_req;
        else           m_own = M1_req;
        #1;
    endtask

    task automatic set_m0(input logic rq, input logic w, input logic [7:0] a, input logic [31:0] d);
        M0_req = rq; M0_wr = w; M0_address = a; M0_dout = d;
    endtask

    task automatic set_m1(input logic rq, input logic w, input logic [7:0] a, input logic [31:0] d);
        M1_req = rq; M1_wr = w; M1_address = a; M1_dout = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_m0(0, 0, 8'h00, 32'h0);
        set_m1(0, 0, 8'h00, 32'h0);
        adv(); adv();
        reset = 1'b0;
        @(negedge Clk);
        checks++; if (M0_grant !== 1'b1) begin errors++; $display("FAIL rst_m0_grant got %b want 1", M0_grant); end
        checks++; if (M1_grant !== 1'b0) begin errors++; $display("FAIL rst_m1_grant got %b want 0", M1_grant); end
        checks++; if (M_din !== 32'h0) begin errors++; $display("FAIL rst_m_din got %h want 0", M_din); end
        checks++; if ({S0_sel, S1_sel, S_wr} !== 3'b000) begin errors++; $display("FAIL rst_selects got %b want 000", {S0_sel, S1_sel, S_wr}); end
        adv();
    endtask

    task automatic init_slaves();
        for (int i = 0; i < 64; i++) begin
            set_m0(1, 1, 8'(i), (i < 4) ? 32'h1111_0000 + 32'(i) : $urandom);
            adv();
        end
        set_m0(0, 0, 8'h00, 32'h0);
        adv();
    endtask

    task automatic test_host_mem();
        set_m0(1, 1, 8'h04, 32'hDEADBEEF);
        @(negedge Clk);
        checks++; if ({S0_sel, S1_sel, S_wr} !== 3'b101) begin errors++; $display("FAIL mem_wr_strobe got %b want 101", {S0_sel, S1_sel, S_wr}); end
        checks++; if ({S_address, S_din} !== {8'h04, 32'hDEADBEEF}) begin errors++; $display("FAIL mem_wr_bus got %h want 04deadbeef", {S_address, S_din}); end
        adv();
        set_m0(1, 0, 8'h04, 32'h0);
        @(negedge Clk);
        checks++; if ({S0_sel, S_wr} !== 2'b10) begin errors++; $display("FAIL mem_rd_sel got %b want 10", {S0_sel, S_wr}); end
        adv();
        set_m0(0, 0, 8'h00, 32'h0);
        @(negedge Clk);
        checks++; if (M_din !== 32'hDEADBEEF) begin errors++; $display("FAIL mem_rd_data got %h want deadbeef", M_din); end
        adv();
    endtask

    task automatic test_dmac_regs();
        logic [7:0]  a;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            a = 8'h20 + 8'(4 * i);
            d = $urandom;
            set_m0(1, 1, a, d);
            @(negedge Clk);
            checks++; if ({S0_sel, S1_sel, S_wr} !== 3'b011) begin errors++; $display("FAIL reg_wr_sel[%0d] got %b want 011", i, {S0_sel, S1_sel, S_wr}); end
            checks++; if ({S_address, S_din} !== {a, d}) begin errors++; $display("FAIL reg_wr_bus[%0d] got %h want %h", i, {S_address, S_din}, {a, d}); end
            adv();
        end
        set_m0(0, 0, 8'h00, 32'h0);
        adv();
    endtask

    task automatic test_handover();
        logic [31:0] d;
        set_m0(1, 0, 8'h05, 32'h0);
        set_m1(1, 0, 8'h00, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            checks++; if ({M0_grant, M1_grant} !== 2'b10) begin errors++; $display("FAIL hold_host[%0d] got %b want 10", k, {M0_grant, M1_grant}); end
            adv();
        end
        set_m0(0, 0, 8'h00, 32'h0);
        @(negedge Clk);
        checks++; if (M1_grant !== 1'b0) begin errors++; $display("FAIL grant_latency got %b want 0", M1_grant); end
        adv();
        for (int i = 0; i < 4; i++) begin
            set_m1(1, 0, 8'(i), 32'h0);
            @(negedge Clk);
            checks++; if ({M1_grant, S0_sel, S_wr} !== 3'b110) begin errors++; $display("FAIL dma_rd[%0d] got %b want 110", i, {M1_grant, S0_sel, S_wr}); end
            adv();
            set_m1(1, 1, 8'h10 + 8'(i), 32'h0);
            @(negedge Clk);
            d = M_din;
            checks++; if (d !== 32'h1111_0000 + 32'(i)) begin errors++; $display("FAIL dma_data[%0d] got %h want %h", i, d, 32'h1111_0000 + 32'(i)); end
            M1_dout = d;
            #1;
            checks++; if ({S0_sel, S_wr, S_din} !== {2'b11, d}) begin errors++; $display("FAIL dma_wr[%0d] got %h want %h", i, {S0_sel, S_wr, S_din}, {2'b11, d}); end
            adv();
        end
        set_m1(0, 0, 8'h00, 32'h0);
        @(negedge Clk);
        checks++; if (M1_grant !== 1'b1) begin errors++; $display("FAIL release_latency got %b want 1", M1_grant); end
        adv();
        @(negedge Clk);
        checks++; if ({M0_grant, M1_grant} !== 2'b10) begin errors++; $display("FAIL release got %b want 10", {M0_grant, M1_grant}); end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) set_m0(1, 0, 8'h10 + 8'(i), 32'h0);
            else       set_m0(0, 0, 8'h00, 32'h0);
            @(negedge Clk);
            if (i > 0) begin
                checks++; if (M_din !== 32'h1111_0000 + 32'(i - 1)) begin errors++; $display("FAIL copy_rb[%0d] got %h want %h", i - 1, M_din, 32'h1111_0000 + 32'(i - 1)); end
            end
            adv();
        end
    endtask

    task automatic test_unmapped();
        set_m0(1, 0, 8'hF0, 32'h0);
        @(negedge Clk);
        checks++; if ({S0_sel, S1_sel} !== 2'b00) begin errors++; $display("FAIL unmap_rd_sel got %b want 00", {S0_sel, S1_sel}); end
        adv();
        set_m0(1, 1, 8'hF0, 32'hBAD0BAD0);
        @(negedge Clk);
        checks++; if (M_din !== 32'h0) begin errors++; $display("FAIL unmap_rd_data got %h want 0", M_din); end
        checks++; if ({S0_sel, S1_sel} !== 2'b00) begin errors++; $display("FAIL unmap_wr_sel got %b want 00", {S0_sel, S1_sel}); end
        adv();
        set_m0(0, 0, 8'h00, 32'h0);
        adv();
    endtask

    task automatic test_reset_mid();
        set_m0(0, 0, 8'h00, 32'h0);
        set_m1(1, 0, 8'h00, 32'h0);
        adv();
        @(negedge Clk);
        checks++; if (M1_grant !== 1'b1) begin errors++; $display("FAIL rmid_grant got %b want 1", M1_grant); end
        adv();
        reset = 1'b1;
        adv();
        reset = 1'b0;
        set_m1(0, 0, 8'h00, 32'h0);
        @(negedge Clk);
        checks++; if ({M0_grant, M1_grant, M_din} !== {2'b10, 32'h0}) begin errors++; $display("FAIL rmid_state got %h want %h", {M0_grant, M1_grant, M_din}, {2'b10, 32'h0}); end
        adv();
    endtask

    task automatic test_random();
        logic [76:0] obs, expv;
        logic [2:0]  hi;
        logic        own, req, wr;
        logic [7:0]  a;
        logic [31:0] d;
        int          r;
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) M0_req = ~M0_req;
            if ($urandom_range(0, 3) == 0) M1_req = ~M1_req;
            M0_wr = 1'($urandom_range(0, 1));
            M1_wr = 1'($urandom_range(0, 1));
            for (int m = 0; m < 2; m++) begin
                r = $urandom_range(0, 9);
                hi = (r < 5) ? 3'd0 : (r < 9) ? 3'd1 : 3'($urandom_range(2, 7));
                a = {hi, 5'($urandom_range(0, 31))};
                if (m == 0) begin M0_address = a; M0_dout = $urandom; end
                else        begin M1_address = a; M1_dout = $urandom; end
            end
            @(negedge Clk);
            if (!reset) begin
                own = m_own;
                req = own ? M1_req : M0_req;
                wr  = own ? M1_wr : M0_wr;
                a   = own ? M1_address : M0_address;
                d   = own ? M1_dout : M0_dout;
                expv = {!own, own, req && a[7:5] == 3'd0, req && a[7:5] == 3'd1, req && wr, a, d, m_rdata};
                obs  = {M0_grant, M1_grant, S0_sel, S1_sel, S_wr, S_address, S_din, M_din};
                checks++;
                if (obs !== expv) begin errors++; $display("FAIL random[%0d] got %h want %h", c, obs, expv); end
            end
            adv();
        end
        reset = 1'b0;
        set_m0(0, 0, 8'h00, 32'h0);
        set_m1(0, 0, 8'h00, 32'h0);
        adv();
    endtask

    task automatic test_slave_image();
        int bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (mem_s0[i] !== r_mem[i]) bad++;
            if (reg_s1[i] !== r_reg[i]) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL slave_image got %0d differing words want 0", bad); end
    endtask

    initial begin
        test_reset();
        init_slaves();
        test_host_mem();
        test_dmac_regs();
        test_handover();
        test_unmapped();
        test_slave_image();
        test_reset_mid();
        test_random();
        test_slave_image();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
